// File: rtl/imuldiv_ctrl_if.sv
// Execute-side bundle for the HI/LO multiply/divide sequencer.
// Execute drives the i_* issue signals; the sequencer drives o_busy/o_stall and HI/LO.
interface imuldiv_ctrl_if #(
   parameter int DATA_W = 32
);
   logic              i_start;
   logic [2:0]        i_op;
   logic [DATA_W-1:0] i_rs;
   logic [DATA_W-1:0] i_rt;
   logic              i_mf_req;
   logic              i_drop;
   logic              o_busy;
   logic              o_stall;
   logic [DATA_W-1:0] o_hi;
   logic [DATA_W-1:0] o_lo;

   modport master (
      output i_start, i_op, i_rs, i_rt, i_mf_req, i_drop,
      input  o_busy, o_stall, o_hi, o_lo
   );

   modport slave (
      input  i_start, i_op, i_rs, i_rt, i_mf_req, i_drop,
      output o_busy, o_stall, o_hi, o_lo
   );
endinterface

// File: rtl/imuldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one bit per cycle, DATA_W cycles
// of CALC followed by a single sign-fix/writeback cycle.
module imuldiv_ctrl #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 5
) (
   input  logic          clk,
   input  logic          rst,
   imuldiv_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t                state, state_nx;
   logic [CNT_W-1:0]      cnt;
   logic [2*DATA_W-1:0]   acc;      // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
   logic [DATA_W-1:0]     opnd;     // multiplicand or divisor magnitude
   logic                  is_div, rs_neg, rt_neg, dz;
   logic [DATA_W-1:0]     hi_q, lo_q;

   logic                  sgn_req, md_req, last;
   logic [DATA_W-1:0]     rs_abs, rt_abs;
   logic [DATA_W:0]       mul_sum, div_shift, div_diff;
   logic [2*DATA_W-1:0]   mul_step, div_step, mul_fix;
   logic [DATA_W-1:0]     quo, rem, div_lo, div_hi;

   assign sgn_req = ~bus.i_op[0];
   assign md_req  = bus.i_start && !bus.i_drop && (bus.i_op <= 3'd3);
   assign rs_abs  = (sgn_req && bus.i_rs[DATA_W-1]) ? -bus.i_rs : bus.i_rs;
   assign rt_abs  = (sgn_req && bus.i_rt[DATA_W-1]) ? -bus.i_rt : bus.i_rt;
   assign last    = (cnt == CNT_W'(DATA_W-1));

   // Shift-add multiply step
   assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
   assign mul_step = {mul_sum, acc[DATA_W-1:1]};

   // Restoring divide step; the remainder stays below the divisor, so DATA_W+1 bits suffice
   assign div_shift = acc[2*DATA_W-1:DATA_W-1];
   assign div_diff  = div_shift - {1'b0, opnd};
   assign div_step  = div_diff[DATA_W] ? {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                                       : {div_diff[DATA_W-1:0],  acc[DATA_W-2:0], 1'b1};

   // With a zero divisor every step "succeeds": quotient is all ones and the remainder is
   // |rs|, so only the quotient negation must be skipped to return LO=~0, HI=rs.
   assign quo     = acc[DATA_W-1:0];
   assign rem     = acc[2*DATA_W-1:DATA_W];
   assign div_lo  = (!dz && (rs_neg ^ rt_neg)) ? -quo : quo;
   assign div_hi  = rs_neg ? -rem : rem;
   assign mul_fix = (rs_neg ^ rt_neg) ? -acc : acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (md_req) state_nx = CALC;
         CALC:    if (bus.i_drop) state_nx = IDLE;
                  else if (last) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         acc    <= '0;
         opnd   <= '0;
         is_div <= 1'b0;
         rs_neg <= 1'b0;
         rt_neg <= 1'b0;
         dz     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (md_req) begin
               cnt    <= '0;
               is_div <= bus.i_op[1];
               rs_neg <= sgn_req && bus.i_rs[DATA_W-1];
               rt_neg <= sgn_req && bus.i_rt[DATA_W-1];
               dz     <= bus.i_op[1] && (bus.i_rt == '0);
               opnd   <= bus.i_op[1] ? rt_abs : rs_abs;
               acc    <= {{DATA_W{1'b0}}, (bus.i_op[1] ? rs_abs : rt_abs)};
            end
            CALC: begin
               cnt <= cnt + 1'b1;
               acc <= is_div ? div_step : mul_step;
            end
            default: ;
         endcase
      end
   end

   // HI/LO are only ever written whole; a drop in the same cycle suppresses the write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (!bus.i_drop) begin
         if (state == IDLE && bus.i_start) begin
            if (bus.i_op == 3'd4) hi_q <= bus.i_rs;
            if (bus.i_op == 3'd5) lo_q <= bus.i_rs;
         end else if (state == FIX) begin
            hi_q <= is_div ? div_hi : mul_fix[2*DATA_W-1:DATA_W];
            lo_q <= is_div ? div_lo : mul_fix[DATA_W-1:0];
         end
      end
   end

   assign bus.o_busy  = (state != IDLE);
   assign bus.o_stall = bus.o_busy && (bus.i_mf_req || (bus.i_start && bus.i_op <= 3'd5));
   assign bus.o_hi    = hi_q;
   assign bus.o_lo    = lo_q;
endmodule

// File: tb/tb_imuldiv_ctrl.sv
// Self-checking bench for imuldiv_ctrl: directed plan cases plus random ops against
// an arithmetic reference model of HI/LO.
module tb_imuldiv_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   pass  = 0;
   logic [31:0] m_hi = '0, m_lo = '0;

   always #5 clk = ~clk;

   imuldiv_ctrl_if #(.DATA_W(32)) bus();
   imuldiv_ctrl #(.DATA_W(32), .CNT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

   function automatic void ref_op(input logic [2:0] op, input logic [31:0] rs, rt,
                                  inout logic [31:0] hi, lo);
      longint a, b, q, r;
      logic [63:0] p;
      case (op)
         3'd0: begin a = longint'($signed(rs)); b = longint'($signed(rt)); p = a * b;
                     hi = p[63:32]; lo = p[31:0]; end
         3'd1: begin p = {32'b0, rs} * {32'b0, rt}; hi = p[63:32]; lo = p[31:0]; end
         3'd2, 3'd3: begin
            if (rt == 0) begin lo = 32'hFFFFFFFF; hi = rs; end
            else begin
               if (op == 3'd2) begin a = longint'($signed(rs)); b = longint'($signed(rt)); end
               else begin a = longint'({32'b0, rs}); b = longint'({32'b0, rt}); end
               q = a / b; r = a % b;
               p = q; lo = p[31:0];
               p = r; hi = p[31:0];
            end
         end
         3'd4: hi = rs;
         3'd5: lo = rs;
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'h80000000;
         2: return 32'hFFFFFFFF;
         3: return 32'($urandom_range(0, 20));
         4: return -32'($urandom_range(1, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic do_op(input logic [2:0] op, input logic [31:0] rs, rt, output int cyc);
      @(negedge clk);
      bus.i_start = 1'b1; bus.i_op = op; bus.i_rs = rs; bus.i_rt = rt;
      @(negedge clk);
      bus.i_start = 1'b0;
      cyc = 0;
      while (bus.o_busy && cyc < 100) begin cyc++; @(negedge clk); end
   endtask

   task automatic test_reset();
      bus.i_start = 0; bus.i_op = 0; bus.i_rs = 0; bus.i_rt = 0; bus.i_drop = 0; bus.i_mf_req = 1;
      repeat (3) @(negedge clk);
      total++; if (bus.o_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.o_busy); else pass++;
      total++; if (bus.o_stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", bus.o_stall); else pass++;
      total++; if (bus.o_hi !== 32'h0) $display("FAIL reset_hi got %h exp 0", bus.o_hi); else pass++;
      total++; if (bus.o_lo !== 32'h0) $display("FAIL reset_lo got %h exp 0", bus.o_lo); else pass++;
      rst = 0; bus.i_mf_req = 0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [2:0]  ops [8] = '{3'd1, 3'd0, 3'd0, 3'd2, 3'd3, 3'd3, 3'd2, 3'd4};
      logic [31:0] rss [8] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9, 32'd100, 32'd100, 32'hFFFFFFF9, 32'h0};
      logic [31:0] rts [8] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd2, 32'd7, 32'd0, 32'd0, 32'h0};
      logic [31:0] ehi [8] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF, 32'd2, 32'd100, 32'hFFFFFFF9, 32'h0};
      logic [31:0] elo [8] = '{32'h00000001, 32'hFFFFFFF1, 32'h00000000, 32'hFFFFFFFD, 32'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      int cyc;
      for (int i = 0; i < 7; i++) begin
         do_op(ops[i], rss[i], rts[i], cyc);
         total++; if (cyc != 33) $display("FAIL dir%0d_latency got %0d exp 33", i, cyc); else pass++;
         total++; if (bus.o_hi !== ehi[i]) $display("FAIL dir%0d_hi got %h exp %h", i, bus.o_hi, ehi[i]); else pass++;
         total++; if (bus.o_lo !== elo[i]) $display("FAIL dir%0d_lo got %h exp %h", i, bus.o_lo, elo[i]); else pass++;
      end
      m_hi = ehi[6]; m_lo = elo[6];
   endtask

   task automatic test_mt();
      int cyc;
      do_op(3'd4, 32'hCAFEF00D, 32'h0, cyc); m_hi = 32'hCAFEF00D;
      do_op(3'd5, 32'h5EED1234, 32'h0, cyc); m_lo = 32'h5EED1234;
      total++; if (cyc != 0) $display("FAIL mt_busy got %0d exp 0", cyc); else pass++;
      do_op(3'd6, 32'h11111111, 32'h0, cyc);
      do_op(3'd7, 32'h22222222, 32'h0, cyc);
      total++; if (bus.o_hi !== m_hi) $display("FAIL mt_hi got %h exp %h", bus.o_hi, m_hi); else pass++;
      total++; if (bus.o_lo !== m_lo) $display("FAIL mt_lo got %h exp %h", bus.o_lo, m_lo); else pass++;
      bus.i_mf_req = 1; #1;
      total++; if (bus.o_stall !== 1'b0) $display("FAIL mf_idle_stall got %b exp 0", bus.o_stall); else pass++;
      bus.i_mf_req = 0;
   endtask

   task automatic test_random();
      int cyc, ecyc;
      logic [2:0] op;
      logic [31:0] rs, rt;
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7)); rs = rnd_val(); rt = rnd_val();
         ref_op(op, rs, rt, m_hi, m_lo);
         ecyc = (op <= 3) ? 33 : 0;
         do_op(op, rs, rt, cyc);
         total++; if (cyc != ecyc) $display("FAIL rnd%0d_latency op%0d got %0d exp %0d", i, op, cyc, ecyc); else pass++;
         total++; if (bus.o_hi !== m_hi) $display("FAIL rnd%0d_hi op%0d rs=%h rt=%h got %h exp %h", i, op, rs, rt, bus.o_hi, m_hi); else pass++;
         total++; if (bus.o_lo !== m_lo) $display("FAIL rnd%0d_lo op%0d rs=%h rt=%h got %h exp %h", i, op, rs, rt, bus.o_lo, m_lo); else pass++;
      end
   endtask

   task automatic test_stall();
      logic exp_st;
      int cyc;
      ref_op(3'd1, 32'hDEADBEEF, 32'h00012345, m_hi, m_lo);
      @(negedge clk);
      bus.i_start = 1; bus.i_op = 3'd1; bus.i_rs = 32'hDEADBEEF; bus.i_rt = 32'h00012345;
      @(negedge clk);
      for (int k = 1; k <= 34; k++) begin
         bus.i_start = (k == 2); bus.i_op = (k == 2) ? 3'd6 : 3'd1;
         bus.i_mf_req = (k >= 3);
         #1 exp_st = (k >= 3 && k <= 33);
         total++; if (bus.o_stall !== exp_st) $display("FAIL mf_stall k=%0d got %b exp %b", k, bus.o_stall, exp_st); else pass++;
         if (k == 34) begin
            total++; if (bus.o_hi !== m_hi) $display("FAIL mf_hi got %h exp %h", bus.o_hi, m_hi); else pass++;
         end
         @(negedge clk);
      end
      bus.i_mf_req = 0;
      // Second request issued while busy is held by the stall
      ref_op(3'd1, 32'h00000123, 32'h00000456, m_hi, m_lo);
      bus.i_start = 1; bus.i_op = 3'd1; bus.i_rs = 32'h00000123; bus.i_rt = 32'h00000456;
      @(negedge clk);
      for (int k = 1; k <= 34; k++) begin
         bus.i_start = (k >= 5 || k == 0);
         if (k == 5) begin bus.i_op = 3'd0; bus.i_rs = 32'hFFFFFF00; bus.i_rt = 32'h00000300; end
         #1 exp_st = (k >= 5 && k <= 33);
         total++; if (bus.o_stall !== exp_st) $display("FAIL req_stall k=%0d got %b exp %b", k, bus.o_stall, exp_st); else pass++;
         if (k == 34) begin
            total++; if (bus.o_lo !== m_lo) $display("FAIL first_lo got %h exp %h", bus.o_lo, m_lo); else pass++;
         end
         @(negedge clk);
      end
      bus.i_start = 0;
      ref_op(3'd0, 32'hFFFFFF00, 32'h00000300, m_hi, m_lo);
      cyc = 0;
      while (bus.o_busy && cyc < 100) begin cyc++; @(negedge clk); end
      total++; if (cyc != 33) $display("FAIL held_latency got %0d exp 33", cyc); else pass++;
      total++; if (bus.o_hi !== m_hi) $display("FAIL held_hi got %h exp %h", bus.o_hi, m_hi); else pass++;
      total++; if (bus.o_lo !== m_lo) $display("FAIL held_lo got %h exp %h", bus.o_lo, m_lo); else pass++;
   endtask

   task automatic test_drop();
      int cyc;
      do_op(3'd4, 32'h12345678, 32'h0, cyc); m_hi = 32'h12345678;
      do_op(3'd5, 32'h0BADF00D, 32'h0, cyc); m_lo = 32'h0BADF00D;
      @(negedge clk);
      bus.i_start = 1; bus.i_op = 3'd3; bus.i_rs = 32'd1000; bus.i_rt = 32'd3;
      @(negedge clk); bus.i_start = 0;
      repeat (9) @(negedge clk);
      bus.i_drop = 1; @(negedge clk); bus.i_drop = 0;
      total++; if (bus.o_busy !== 1'b0) $display("FAIL drop_calc_busy got %b exp 0", bus.o_busy); else pass++;
      total++; if (bus.o_hi !== m_hi) $display("FAIL drop_calc_hi got %h exp %h", bus.o_hi, m_hi); else pass++;
      // Drop landing on the writeback cycle
      bus.i_start = 1; bus.i_op = 3'd1; bus.i_rs = 32'd7; bus.i_rt = 32'd9;
      @(negedge clk); bus.i_start = 0;
      repeat (32) @(negedge clk);
      total++; if (bus.o_busy !== 1'b1) $display("FAIL fix_busy got %b exp 1", bus.o_busy); else pass++;
      bus.i_drop = 1; @(negedge clk); bus.i_drop = 0;
      total++; if (bus.o_busy !== 1'b0) $display("FAIL drop_fix_busy got %b exp 0", bus.o_busy); else pass++;
      total++; if (bus.o_lo !== m_lo) $display("FAIL drop_fix_lo got %h exp %h", bus.o_lo, m_lo); else pass++;
      // Drop with a start in IDLE
      bus.i_start = 1; bus.i_drop = 1; bus.i_op = 3'd4; bus.i_rs = 32'hFFFF0000;
      @(negedge clk);
      bus.i_op = 3'd0;
      @(negedge clk);
      bus.i_start = 0; bus.i_drop = 0;
      total++; if (bus.o_hi !== m_hi) $display("FAIL drop_mthi got %h exp %h", bus.o_hi, m_hi); else pass++;
      total++; if (bus.o_busy !== 1'b0) $display("FAIL drop_start_busy got %b exp 0", bus.o_busy); else pass++;
   endtask

   task automatic test_rst_mid();
      bus.i_start = 1; bus.i_op = 3'd0; bus.i_rs = 32'h00001234; bus.i_rt = 32'h00005678;
      @(negedge clk); bus.i_start = 0;
      repeat (10) @(negedge clk);
      #2 rst = 1;
      #1;
      total++; if (bus.o_busy !== 1'b0) $display("FAIL rst_mid_busy got %b exp 0", bus.o_busy); else pass++;
      total++; if (bus.o_hi !== 32'h0) $display("FAIL rst_mid_hi got %h exp 0", bus.o_hi); else pass++;
      total++; if (bus.o_lo !== 32'h0) $display("FAIL rst_mid_lo got %h exp 0", bus.o_lo); else pass++;
      @(negedge clk); rst = 0; m_hi = 0; m_lo = 0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_mt();
      test_random();
      test_stall();
      test_drop();
      test_rst_mid();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule

// File: doc/imuldiv_ctrl.md
Name: imuldiv_ctrl

Overview:
Iterative integer multiply/divide sequencer owning the HI/LO register pair. It sits beside the execute stage and receives operands and an operation code when execute issues MULT/MULTU/DIV/DIVU/MTHI/MTLO. It raises a stall to the control unit while a result is pending and an MFHI/MFLO or a new multiply/divide request arrives. HI/LO values are read directly by execute.

Parameters:
DATA_W, 32, operand and HI/LO width; the iteration count equals DATA_W.
CNT_W, 5, iteration counter width; must be >= clog2(DATA_W).

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  reset; asynchronous, active-high.
i_start  in  1  operation issue strobe from execute.
i_op  in  3  op code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are ignored (no action, no stall).
i_rs  in  DATA_W  rs operand: multiplicand, dividend, or MTHI/MTLO source.
i_rt  in  DATA_W  rt operand: multiplier or divisor.
i_mf_req  in  1  an MFHI/MFLO is in execute this cycle.
i_drop  in  1  pipeline flush; aborts the in-flight operation.
o_busy  out  1  an operation is in progress.
o_stall  out  1  stall request to the control unit (combinational).
o_hi  out  DATA_W  HI register.
o_lo  out  DATA_W  LO register.

Behaviour:
- Reset, when rst is high, asynchronously sets:
  - state to IDLE, counter to 0;
  - o_hi and o_lo to 0, o_busy to 0;
  - all internal working registers to 0.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - i_start with op 0-3 and no i_drop: latch operand magnitudes. For signed ops (0, 2), take the absolute value of each operand in two's complement. Also latch the sign flags, the op type and the divide-by-zero flag (rt == 0 on op 2/3). Clear the counter and the accumulator, then move to CALC.
  - i_start with op 4: o_hi <= i_rs on the same edge; op 5: o_lo <= i_rs on the same edge. The state stays IDLE and o_busy stays 0.
- CALC: one iteration per cycle, DATA_W cycles, counter 0 to DATA_W-1.
  - Multiply: shift-add on a 2*DATA_W-bit product register.
  - Divide: restoring division; the remainder register is shifted left by 1 and the divisor subtracted if non-negative; the quotient bit is shifted in.
  - On counter == DATA_W-1, move to FIX.
- FIX: one cycle.
  - Multiply: negate the 2*DATA_W-bit product if op 0 and the operand signs differ. HI gets the upper half, LO the lower half.
  - Divide: LO gets the quotient, negated if op 2 and the signs differ. HI gets the remainder, negated if op 2 and the dividend was negative.
  - Divide by zero: sign fixing is skipped; LO = all ones, HI = original i_rs.
  - Write o_hi/o_lo, then move to IDLE.
- Latency: if start is sampled at edge N, o_busy = 1 from after N until edge N+33. HI/LO are updated at edge N+33 and o_busy is 0 after it.
- o_busy = (state != IDLE).
- o_stall = o_busy && (i_mf_req || (i_start && i_op <= 5)).
  - A request that arrives while busy is held by the stall. It is accepted on the first cycle the block is IDLE.
- i_drop:
  - In CALC or FIX, forces IDLE on the next edge. HI/LO are not written and keep their prior values.
  - In IDLE with i_start, the start is ignored, including MTHI/MTLO.
  - i_drop takes priority over all other events.
- HI/LO are never partially updated. A drop asserted in the FIX cycle suppresses the write.
- MF while idle: no stall; o_hi/o_lo hold current values.
- Arithmetic wrap: the magnitude of 0x80000000 is 0x80000000, treated as unsigned 2^31. The results below follow from this.

Test Plan:
1. MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> o_busy high for 33 cycles; then HI=0xFFFFFFFE, LO=0x00000001.
2. MULT rs=0xFFFFFFFD (-3), rt=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0x00000000.
3. DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
4. DIVU rs=100, rt=0 -> LO=0xFFFFFFFF, HI=0x00000064. DIV rs=-7, rt=0 -> LO=0xFFFFFFFF, HI=0xFFFFFFF9.
5. Start MULTU, then hold i_mf_req from cycle 3 -> o_stall=1 until the edge where HI/LO update, 0 the following cycle with correct HI. A second MULT issued while busy stalls and starts at the first idle cycle.
6. MTHI 0x12345678 preload, start DIVU, pulse i_drop at cycle 10 -> o_busy=0 after the next edge; HI stays 0x12345678. Assert rst mid-CALC -> HI=LO=0, o_busy=0 immediately.
